// File: rtl/cmd_dispatcher_pkg.sv
// Shared definitions for the host-command dispatcher: FSM states, opcodes, status codes and
// engine indices.
package cmd_dispatcher_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StDecode,
        StDispatch,
        StWaitDone,
        StAck
    } state_e;

    localparam logic [7:0] OpVec  = 8'h03;
    localparam logic [7:0] OpCfg  = 8'h04;
    localparam logic [7:0] OpTest = 8'h05;
    localparam logic [7:0] OpRead = 8'h06;

    localparam logic [7:0] AckFlag    = 8'h80;
    localparam logic [7:0] AckData    = 8'h8F;
    localparam logic [7:0] NakByteTo  = 8'hE1;
    localparam logic [7:0] NakOpcode  = 8'hE2;
    localparam logic [7:0] NakOverrun = 8'hE3;
    localparam logic [7:0] NakDoneTo  = 8'hE4;

    localparam logic [1:0] EngCfg  = 2'd0;
    localparam logic [1:0] EngVec  = 2'd1;
    localparam logic [1:0] EngTest = 2'd2;
    localparam logic [1:0] EngRead = 2'd3;

    function automatic logic [3:0] eng_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/cmd_dispatcher_cycle_timer.sv
// Saturating cycle counter with synchronous clear; flags once TIMEOUT cycles have been counted.
module cycle_timer #(
    parameter int unsigned TIMEOUT = 20000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = $clog2(TIMEOUT + 1);

    logic [W-1:0] count_q;

    assign expired = (count_q == W'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/cmd_dispatcher.sv
// Host-command front end: assembles UART packets, starts one engine, waits for its DONE and
// returns a one-byte ACK/NAK.
module cmd_dispatcher
    import cmd_dispatcher_pkg::*;
#(
    parameter int unsigned PKT_BYTES    = 16,
    parameter int unsigned BYTE_TIMEOUT = 20000,
    parameter int unsigned DONE_TIMEOUT = 5000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [8*PKT_BYTES-1:0] pkt,
    output logic                   pkt_is_data,
    output logic [3:0]             start,
    output logic [3:0]             abort,
    input  logic [3:0]             done
);

    localparam int unsigned CW = $clog2(PKT_BYTES);

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [8*PKT_BYTES-1:0] pkt_q, pkt_d;
    logic [1:0]             target_q, target_d;
    logic [7:0]             status_q, status_d;
    logic                   is_data_q, is_data_d;
    logic                   vec_pend_q, vec_pend_d;
    logic                   overrun_q, overrun_d;
    logic [3:0]             abort_q, abort_d;
    logic                   byte_exp, wd_exp;
    logic                   busy, ovr_now, to_ack, nak_timeout;
    logic [7:0]             new_status;

    cycle_timer #(.TIMEOUT(BYTE_TIMEOUT)) u_byte_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   ((state_q != StRecv) || rx_valid),
        .enable  (state_q == StRecv),
        .expired (byte_exp)
    );

    cycle_timer #(.TIMEOUT(DONE_TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_q != StWaitDone),
        .enable  (state_q == StWaitDone),
        .expired (wd_exp)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pkt_d       = pkt_q;
        target_d    = target_q;
        status_d    = status_q;
        is_data_d   = is_data_q;
        vec_pend_d  = vec_pend_q;
        abort_d     = '0;
        to_ack      = 1'b0;
        nak_timeout = 1'b0;
        new_status  = status_q;
        // Bytes arriving while a packet is being processed are dropped but remembered.
        busy        = (state_q != StIdle) && (state_q != StRecv);
        ovr_now     = overrun_q || (rx_valid && busy);
        overrun_d   = ovr_now;

        case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    pkt_d[7:0] = rx_data;
                    cnt_d      = CW'(1);
                    state_d    = StRecv;
                end
            end
            StRecv: begin
                if (rx_valid) begin
                    pkt_d[8*cnt_q +: 8] = rx_data;
                    cnt_d               = cnt_q + 1'b1;
                    if (cnt_q == CW'(PKT_BYTES - 1)) begin
                        state_d = StDecode;
                    end
                end else if (byte_exp) begin
                    new_status  = NakByteTo;
                    nak_timeout = 1'b1;
                    to_ack      = 1'b1;
                end
            end
            StDecode: begin
                state_d = StDispatch;
                if (vec_pend_q) begin
                    is_data_d  = 1'b1;
                    target_d   = EngVec;
                    vec_pend_d = 1'b0;
                end else begin
                    case (pkt_q[7:0])
                        OpCfg:   target_d = EngCfg;
                        OpVec:   target_d = EngVec;
                        OpTest:  target_d = EngTest;
                        OpRead:  target_d = EngRead;
                        default: begin
                            new_status = NakOpcode;
                            to_ack     = 1'b1;
                        end
                    endcase
                end
            end
            StDispatch: begin
                state_d = StWaitDone;
            end
            StWaitDone: begin
                if (done[target_q]) begin
                    new_status = is_data_q ? AckData : (AckFlag | pkt_q[7:0]);
                    to_ack     = 1'b1;
                end else if (wd_exp) begin
                    abort_d     = eng_onehot(target_q);
                    new_status  = NakDoneTo;
                    nak_timeout = 1'b1;
                    to_ack      = 1'b1;
                end
            end
            StAck: begin
                if (tx_ready) begin
                    state_d   = StIdle;
                    is_data_d = 1'b0;
                    if (status_q == (AckFlag | OpVec)) begin
                        vec_pend_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Timeout NAKs outrank the overrun NAK and leave the overrun flag pending.
        if (to_ack) begin
            state_d = StAck;
            if (!nak_timeout && ovr_now) begin
                status_d  = NakOverrun;
                overrun_d = 1'b0;
            end else begin
                status_d = new_status;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            pkt_q      <= '0;
            target_q   <= '0;
            status_q   <= '0;
            is_data_q  <= 1'b0;
            vec_pend_q <= 1'b0;
            overrun_q  <= 1'b0;
            abort_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pkt_q      <= pkt_d;
            target_q   <= target_d;
            status_q   <= status_d;
            is_data_q  <= is_data_d;
            vec_pend_q <= vec_pend_d;
            overrun_q  <= overrun_d;
            abort_q    <= abort_d;
        end
    end

    assign pkt         = pkt_q;
    assign pkt_is_data = is_data_q;
    assign abort       = abort_q;
    assign start       = (state_q == StDispatch) ? eng_onehot(target_q) : 4'b0000;
    assign tx_valid    = (state_q == StAck);
    assign tx_data     = tx_valid ? status_q : 8'h00;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Bench for cmd_dispatcher: directed table, multi-cycle corner sequences and a randomized
// transaction stream checked against a packet-level model.
module tb_cmd_dispatcher;

    localparam int PB = 16;
    localparam int BT = 200;
    localparam int DT = 400;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [7:0]     rx_data;
    logic           rx_valid;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic [8*PB-1:0] pkt;
    logic           pkt_is_data;
    logic [3:0]     start;
    logic [3:0]     abort;
    logic [3:0]     done;

    int n_vec = 0;
    int n_err = 0;

    cmd_dispatcher #(
        .PKT_BYTES    (PB),
        .BYTE_TIMEOUT (BT),
        .DONE_TIMEOUT (DT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .pkt         (pkt),
        .pkt_is_data (pkt_is_data),
        .start       (start),
        .abort       (abort),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b0;
        logic [3:0] st;
        logic       dat;
        logic [7:0] tx;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_start"}, 128'(start), 128'(0));
        chk({tag, "_abort"}, 128'(abort), 128'(0));
        chk({tag, "_txv"}, 128'(tx_valid), 128'(0));
        chk({tag, "_txd"}, 128'(tx_data), 128'(0));
        chk({tag, "_pkt"}, pkt, 128'(0));
        chk({tag, "_isdata"}, 128'(pkt_is_data), 128'(0));
    endtask

    function automatic logic [127:0] rnd_pkt(input logic [7:0] b0);
        logic [127:0] p;
        p = {$urandom(), $urandom(), $urandom(), $urandom()};
        p[7:0] = b0;
        return p;
    endfunction

    task automatic send_pkt(input logic [127:0] p, input int max_gap);
        for (int k = 0; k < PB; k++) begin
            rx_data  = p[8*k +: 8];
            rx_valid = 1'b1;
            step();
            rx_valid = 1'b0;
            if (k != PB - 1) repeat ($urandom_range(max_gap, 0)) step();
        end
    endtask

    task automatic handshake(input logic [7:0] exp_tx, input int rdy_dly);
        int k;
        k = 0;
        while (!tx_valid && k < 20) begin
            step();
            k++;
        end
        chk("tx_valid_seen", 128'(tx_valid), 128'(1));
        chk("tx_data", 128'(tx_data), 128'(exp_tx));
        for (int i = 0; i < rdy_dly; i++) begin
            step();
            chk("tx_valid_held", 128'(tx_valid), 128'(1));
        end
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        chk("tx_valid_drop", 128'(tx_valid), 128'(0));
        chk("isdata_clear", 128'(pkt_is_data), 128'(0));
    endtask

    // One full command/data transaction; give_done=0 lets the watchdog fire.
    task automatic do_txn(input logic [127:0] p, input logic [3:0] exp_start, input logic exp_dat,
                          input logic [7:0] exp_tx, input int done_dly, input int stray,
                          input bit give_done, input int rdy_dly, input int max_gap);
        int k;
        send_pkt(p, max_gap);
        chk("start_t1", 128'(start), 128'(0));
        chk("pkt_t1", pkt, p);
        step();
        chk("start_t2", 128'(start), 128'(exp_start));
        chk("isdata_t2", 128'(pkt_is_data), 128'(exp_dat));
        if (exp_start != 4'b0000) begin
            step();
            chk("start_once", 128'(start), 128'(0));
            for (int i = 0; i < stray; i++) begin
                rx_data  = 8'($urandom());
                rx_valid = 1'b1;
                done     = 4'($urandom()) & ~exp_start;
                step();
                rx_valid = 1'b0;
            end
            if (give_done) begin
                for (int i = stray; i < done_dly; i++) begin
                    done = 4'($urandom()) & ~exp_start;
                    step();
                end
                done = exp_start | (4'($urandom()) & ~exp_start);
                step();
                done = 4'b0000;
            end else begin
                k = 0;
                while (abort == 4'b0000 && k < DT + 20) begin
                    done = 4'($urandom()) & ~exp_start;
                    step();
                    k++;
                end
                done = 4'b0000;
                chk("abort", 128'(abort), 128'(exp_start));
            end
            chk("pkt_hold", pkt, p);
        end
        handshake(exp_tx, rdy_dly);
    endtask

    vec_t tbl[6];

    initial begin
        logic [127:0] p;
        logic [7:0]   op;
        int           k;
        bit           m_vec_pending;
        bit           m_overrun;

        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        done     = 4'b0000;

        tbl[0] = '{8'h04, 4'b0001, 1'b0, 8'h84};
        tbl[1] = '{8'h03, 4'b0010, 1'b0, 8'h83};
        tbl[2] = '{8'hAA, 4'b0010, 1'b1, 8'h8F};
        tbl[3] = '{8'h07, 4'b0000, 1'b0, 8'hE2};
        tbl[4] = '{8'h05, 4'b0100, 1'b0, 8'h85};
        tbl[5] = '{8'h06, 4'b1000, 1'b0, 8'h86};

        repeat (3) step();
        chk_quiet("reset");
        rst_n = 1'b1;
        step();

        // Directed table: cfg, vec header + data, unknown opcode, test, read.
        for (int i = 0; i < 6; i++) begin
            p = (i == 0) ? {{15{8'hFF}}, 8'h04} : rnd_pkt(tbl[i].b0);
            do_txn(p, tbl[i].st, tbl[i].dat, tbl[i].tx, i, 0, 1'b1, 0, 0);
        end

        // DONE withheld -> abort and E4; then stray bytes with DONE -> E3.
        do_txn(rnd_pkt(8'h05), 4'b0100, 1'b0, 8'hE4, 0, 0, 1'b0, 0, 0);
        do_txn(rnd_pkt(8'h05), 4'b0100, 1'b0, 8'hE3, 8, 3, 1'b1, 0, 0);

        // Byte timeout after 7 bytes, then a clean read packet.
        p = rnd_pkt(8'h06);
        for (int b = 0; b < 7; b++) begin
            rx_data  = p[8*b +: 8];
            rx_valid = 1'b1;
            step();
            rx_valid = 1'b0;
        end
        k = 0;
        while (!tx_valid && k < BT + 20) begin
            step();
            k++;
        end
        chk("byte_to_not_early", 128'(k >= BT), 128'(1));
        handshake(8'hE1, 0);
        do_txn(rnd_pkt(8'h06), 4'b1000, 1'b0, 8'h86, 2, 0, 1'b1, 0, 0);

        // Async reset in the middle of a packet.
        p = rnd_pkt(8'h04);
        for (int b = 0; b < 8; b++) begin
            rx_data  = p[8*b +: 8];
            rx_valid = 1'b1;
            step();
            rx_valid = 1'b0;
        end
        rx_data  = 8'h5A;
        rx_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_quiet("async_rst");
        rx_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        do_txn(rnd_pkt(8'h04), 4'b0001, 1'b0, 8'h84, 1, 0, 1'b1, 4, 0);

        // Randomized transaction stream against a packet-level model.
        m_vec_pending = 1'b0;
        m_overrun     = 1'b0;
        for (int t = 0; t < 40; t++) begin
            logic [3:0] st;
            logic [7:0] exp_tx;
            logic       dat;
            bit         gd;
            int         stray;
            bit         ovr;
            dat   = 1'b0;
            stray = 0;
            gd    = 1'b1;
            if (m_vec_pending) begin
                op            = 8'($urandom());
                st            = 4'b0010;
                dat           = 1'b1;
                m_vec_pending = 1'b0;
            end else begin
                case ($urandom_range(4, 0))
                    0: op = 8'h03;
                    1: op = 8'h04;
                    2: op = 8'h05;
                    3: op = 8'h06;
                    default: begin
                        op = 8'($urandom());
                        while (op >= 8'h03 && op <= 8'h06) op = 8'($urandom());
                    end
                endcase
                st = (op == 8'h04) ? 4'b0001 : (op == 8'h03) ? 4'b0010 :
                     (op == 8'h05) ? 4'b0100 : (op == 8'h06) ? 4'b1000 : 4'b0000;
            end
            if (st == 4'b0000) begin
                exp_tx    = m_overrun ? 8'hE3 : 8'hE2;
                m_overrun = 1'b0;
            end else begin
                gd    = ($urandom_range(7, 0) != 0);
                stray = (!dat && op == 8'h03) ? 0 : $urandom_range(2, 0);
                ovr   = m_overrun || (stray > 0);
                if (!gd) begin
                    exp_tx    = 8'hE4;
                    m_overrun = ovr;
                end else begin
                    exp_tx    = ovr ? 8'hE3 : (dat ? 8'h8F : (8'h80 | op));
                    m_overrun = 1'b0;
                    if (!dat && op == 8'h03 && !ovr) m_vec_pending = 1'b1;
                end
            end
            do_txn(rnd_pkt(op), st, dat, exp_tx, $urandom_range(10, 0), stray, gd,
                   $urandom_range(3, 0), 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
